// File: rtl/conv_collect_pkg.sv
// Shared types and frame geometry for the conv result collector.
// CONV_COLLECT_BINARIZE_EN selects 1-bit sign storage instead of full-width results.
package conv_collect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic MODE_24X24 = 1'b0;
  localparam logic MODE_8X8   = 1'b1;

  localparam int FRAME_W_24 = 24;
  localparam int FRAME_W_8  = 8;
  localparam int FRAME_N_24 = 576;
  localparam int FRAME_N_8  = 64;

`ifdef CONV_COLLECT_BINARIZE_EN
  localparam bit BINARIZE_EN = 1'b1;
`else
  localparam bit BINARIZE_EN = 1'b0;
`endif

  // A binarized buffer keeps only the sign decision, so one bit per entry.
  function automatic int buf_word_w(input int data_w);
    return BINARIZE_EN ? 1 : data_w;
  endfunction

endpackage

// File: rtl/conv_collect_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Read data holds its value while i_rd_en is low, so it doubles as a prefetch stage.
module conv_collect_ram
  import conv_collect_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 576,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdData;

  // No reset here so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rdData <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rdData;

endmodule

// File: rtl/conv_collect.sv
// Captures one conv output frame into a buffer, then replays it in raster order
// over valid/ready with row/col tags. CONV_COLLECT_BINARIZE_EN stores sign bits only.
module conv_collect
  import conv_collect_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 576,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_state,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_done,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [4:0]        o_out_row,
  output logic [4:0]        o_out_col,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_err_short,
  output logic              o_err_overflow
);

  localparam int WORD_W = buf_word_w(DATA_W);
  localparam int CNT_W  = ADDR_W + 1;

  state_t r_state, w_nextState;

  logic              r_mode;
  logic [CNT_W-1:0]  r_wrCnt;
  logic              r_errShort, r_errOverflow;

  logic [CNT_W-1:0]  r_rdIdx;
  logic [4:0]        r_rdRow, r_rdCol;
  logic              r_pfValid, r_pfLast;
  logic [4:0]        r_pfRow, r_pfCol;

  logic              r_outValid, r_outLast;
  logic [DATA_W-1:0] r_outData;
  logic [4:0]        r_outRow, r_outCol;

  logic              w_modeEff;
  logic [CNT_W-1:0]  w_frameN;
  logic [4:0]        w_lastCol;
  logic              w_full, w_wrEn, w_drop, w_frameStart, w_doneAccept, w_busy;
  logic [ADDR_W-1:0] w_wrAddr;
  logic [CNT_W-1:0]  w_capCnt;
  logic              w_outFire, w_outLoad, w_pfAdvance, w_rdEn;
  logic [WORD_W-1:0] w_wrData, w_rdData;
  logic [DATA_W-1:0] w_rdExt;

  // Geometry follows the live mode input until a frame starts, then the latched mode.
  always_comb begin
    w_modeEff = (r_state == ST_IDLE) ? i_state : r_mode;
    w_frameN  = (w_modeEff == MODE_8X8) ? CNT_W'(FRAME_N_8) : CNT_W'(FRAME_N_24);
    w_lastCol = (w_modeEff == MODE_8X8) ? 5'(FRAME_W_8 - 1) : 5'(FRAME_W_24 - 1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (i_in_valid) w_nextState = i_in_done ? ST_DRAIN : ST_FILL;
      ST_FILL:  if (i_in_done) w_nextState = ST_DRAIN;
      ST_DRAIN: if (w_outFire && r_outLast) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy       = (r_state != ST_IDLE);
    w_full       = (r_wrCnt == w_frameN);
    w_wrEn       = 1'b0;
    w_drop       = 1'b0;
    w_frameStart = 1'b0;
    w_doneAccept = 1'b0;
    w_wrAddr     = r_wrCnt[ADDR_W-1:0];
    case (r_state)
      ST_IDLE: begin
        w_wrEn       = i_in_valid;
        w_frameStart = i_in_valid;
        w_doneAccept = i_in_valid && i_in_done;
        w_wrAddr     = '0;
      end
      ST_FILL: begin
        w_wrEn       = i_in_valid && !w_full;
        w_drop       = i_in_valid && w_full;
        w_doneAccept = i_in_done;
      end
      ST_DRAIN: begin
        w_drop = i_in_valid;
      end
      default: begin
        w_wrEn = 1'b0;
      end
    endcase
    w_capCnt = ((r_state == ST_IDLE) ? '0 : r_wrCnt) + CNT_W'(w_wrEn);
  end

`ifdef CONV_COLLECT_BINARIZE_EN
  assign w_wrData = ~i_in_data[DATA_W-1];
  assign w_rdExt  = {{(DATA_W-1){1'b0}}, w_rdData[0]};
`else
  assign w_wrData = i_in_data;
  assign w_rdExt  = w_rdData;
`endif

  // Capture side: write count doubles as the drain length once the frame closes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode        <= MODE_24X24;
      r_wrCnt       <= '0;
      r_errShort    <= 1'b0;
      r_errOverflow <= 1'b0;
    end else begin
      if (w_frameStart) begin
        r_mode        <= i_state;
        r_errShort    <= 1'b0;
        r_errOverflow <= 1'b0;
      end
      if (w_wrEn) begin
        r_wrCnt <= w_capCnt;
      end
      if (w_drop) begin
        r_errOverflow <= 1'b1;
      end
      if (w_doneAccept && (w_capCnt != w_frameN)) begin
        r_errShort <= 1'b1;
      end
    end
  end

  assign w_outFire   = r_outValid && i_out_ready;
  assign w_outLoad   = !r_outValid || w_outFire;
  assign w_pfAdvance = r_pfValid && w_outLoad;
  assign w_rdEn      = (r_state == ST_DRAIN) && (r_rdIdx < r_wrCnt) && (!r_pfValid || w_pfAdvance);

  // Two-stage replay: RAM output acts as prefetch, output register faces downstream.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdIdx    <= '0;
      r_rdRow    <= '0;
      r_rdCol    <= '0;
      r_pfValid  <= 1'b0;
      r_pfLast   <= 1'b0;
      r_pfRow    <= '0;
      r_pfCol    <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_outData  <= '0;
      r_outRow   <= '0;
      r_outCol   <= '0;
    end else if (r_state != ST_DRAIN) begin
      r_rdIdx    <= '0;
      r_rdRow    <= '0;
      r_rdCol    <= '0;
      r_pfValid  <= 1'b0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end else begin
      if (w_rdEn) begin
        r_pfValid <= 1'b1;
        r_pfRow   <= r_rdRow;
        r_pfCol   <= r_rdCol;
        r_pfLast  <= (r_rdIdx == r_wrCnt - CNT_W'(1));
        r_rdIdx   <= r_rdIdx + CNT_W'(1);
        if (r_rdCol == w_lastCol) begin
          r_rdCol <= '0;
          r_rdRow <= r_rdRow + 5'd1;
        end else begin
          r_rdCol <= r_rdCol + 5'd1;
        end
      end else if (w_pfAdvance) begin
        r_pfValid <= 1'b0;
      end
      if (w_pfAdvance) begin
        r_outValid <= 1'b1;
        r_outData  <= w_rdExt;
        r_outRow   <= r_pfRow;
        r_outCol   <= r_pfCol;
        r_outLast  <= r_pfLast;
      end else if (w_outFire) begin
        r_outValid <= 1'b0;
        r_outLast  <= 1'b0;
      end
    end
  end

  conv_collect_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk    (i_clk),
    .i_wr_en  (w_wrEn),
    .i_wr_addr(w_wrAddr),
    .i_wr_data(w_wrData),
    .i_rd_en  (w_rdEn),
    .i_rd_addr(r_rdIdx[ADDR_W-1:0]),
    .o_rd_data(w_rdData)
  );

  assign o_out_valid    = r_outValid;
  assign o_out_data     = r_outData;
  assign o_out_row      = r_outRow;
  assign o_out_col      = r_outCol;
  assign o_out_last     = r_outLast;
  assign o_busy         = w_busy;
  assign o_err_short    = r_errShort;
  assign o_err_overflow = r_errOverflow;

endmodule

// File: tb/tb_conv_collect.sv
// Randomized bench for conv_collect with a frame-level reference model.
// Build with CONV_COLLECT_BINARIZE_EN to also exercise sign capture.
module tb_conv_collect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        state = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_done = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_row, out_col;
  logic        out_last, busy, err_short, err_overflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] stim[$];
  logic [31:0] obsData[$];
  int          obsRow[$], obsCol[$];
  bit          obsLast[$];
  logic [31:0] expData[$];
  int          expRow[$], expCol[$];
  bit          expLast[$];
  bit          expShort, expOvf;
  int          latency, busyAfterFirst, stallErrs;

  logic [31:0] prevData;
  logic [4:0]  prevRow, prevCol;
  logic        prevLast;
  bit          prevStall = 1'b0;

  always #5 clk = ~clk;

  conv_collect #(.DATA_W(32), .DEPTH(576), .ADDR_W(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_state(state),
    .i_in_valid(in_valid), .i_in_data(in_data), .i_in_done(in_done),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_row(out_row), .o_out_col(out_col), .o_out_last(out_last),
    .o_busy(busy), .o_err_short(err_short), .o_err_overflow(err_overflow)
  );

  // Observes the stream mid-cycle: records transfers and stall-stability breaks.
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall && (!out_valid || out_data !== prevData || out_row !== prevRow ||
                        out_col !== prevCol || out_last !== prevLast))
        stallErrs++;
      prevStall = out_valid && !out_ready;
      prevData = out_data; prevRow = out_row; prevCol = out_col; prevLast = out_last;
      if (out_valid && out_ready) begin
        obsData.push_back(out_data);
        obsRow.push_back(int'(out_row));
        obsCol.push_back(int'(out_col));
        obsLast.push_back(out_last);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: frame keeps the first min(sent, N) samples in raster order.
  task automatic buildExpected(input int mode);
    int n, w, cap;
    n = (mode == 1) ? 64 : 576;
    w = (mode == 1) ? 8 : 24;
    cap = (stim.size() < n) ? stim.size() : n;
    expData.delete(); expRow.delete(); expCol.delete(); expLast.delete();
    for (int i = 0; i < cap; i++) begin
`ifdef CONV_COLLECT_BINARIZE_EN
      expData.push_back(($signed(stim[i]) >= 0) ? 32'd1 : 32'd0);
`else
      expData.push_back(stim[i]);
`endif
      expRow.push_back(i / w);
      expCol.push_back(i % w);
      expLast.push_back(i == cap - 1);
    end
    expShort = (cap != n);
    expOvf   = (stim.size() > n);
  endtask

  // Sends stim[] as one frame, then drains it; called at #1 after a rising edge.
  task automatic runFrame(input int mode, input bit doneWithLast, input int gapPct,
                          input int stallPct, input bit toggleMode);
    int idx, cyc;
    obsData.delete(); obsRow.delete(); obsCol.delete(); obsLast.delete();
    stallErrs = 0;
    idx = 0;
    state = 1'(mode);
    while (idx < stim.size()) begin
      out_ready = ($urandom_range(99) >= stallPct);
      if (idx > 0 && toggleMode) state = 1'($urandom_range(1));
      if (idx > 0 && $urandom_range(99) < gapPct) begin
        in_valid = 1'b0; in_done = 1'b0;
        @(posedge clk); #1;
      end else begin
        in_valid = 1'b1;
        in_data  = stim[idx];
        in_done  = doneWithLast && (idx == stim.size() - 1);
        idx++;
        @(posedge clk); #1;
        if (idx == 1) busyAfterFirst = int'(busy);
      end
    end
    in_valid = 1'b0; in_done = 1'b0;
    if (!doneWithLast) begin
      in_done = 1'b1;
      @(posedge clk); #1;
      in_done = 1'b0;
    end
    latency = 0;
    while (!out_valid && latency < 20) begin
      out_ready = ($urandom_range(99) >= stallPct);
      @(posedge clk); #1;
      latency++;
    end
    cyc = 0;
    while (busy && cyc < 5000) begin
      out_ready = ($urandom_range(99) >= stallPct);
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: busy=%0b after %0d cycles, required 0", busy, cyc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset.busy: got %0b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset.out_valid: got %0b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset.out_last: got %0b want 0", out_last); end
    checks++; if (err_short !== 1'b0) begin errors++; $display("[TB] FAIL reset.err_short: got %0b want 0", err_short); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset.err_overflow: got %0b want 0", err_overflow); end
    checks++; if ({out_data, out_row, out_col} !== 42'd0) begin errors++; $display("[TB] FAIL reset.data_row_col: got %h/%0d/%0d want 0/0/0", out_data, out_row, out_col); end
    rst = 1'b0;
  endtask

  task automatic test_full_frame;
    int lastCount;
    stim.delete();
    for (int i = 0; i < 576; i++) stim.push_back(32'(i - 288));
    runFrame(0, 1'b1, 0, 0, 1'b0);
    buildExpected(0);
    checks++; if (obsData.size() != expData.size()) begin errors++; $display("[TB] FAIL full.count: got %0d want %0d", obsData.size(), expData.size()); end
    for (int i = 0; i < expData.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin errors++; $display("[TB] FAIL full.sample[%0d]: got nothing want %h", i, expData[i]); end
      else if ({obsData[i], obsRow[i], obsCol[i], obsLast[i]} !== {expData[i], expRow[i], expCol[i], expLast[i]}) begin
        errors++;
        $display("[TB] FAIL full.sample[%0d]: got %h r%0d c%0d l%0b want %h r%0d c%0d l%0b", i,
                 obsData[i], obsRow[i], obsCol[i], obsLast[i], expData[i], expRow[i], expCol[i], expLast[i]);
      end
    end
    lastCount = 0;
    foreach (obsLast[i]) if (obsLast[i]) lastCount++;
    checks++; if (lastCount != 1) begin errors++; $display("[TB] FAIL full.last_count: got %0d want 1", lastCount); end
    checks++; if (obsRow.size() == 0 || obsRow[$] != 23 || obsCol[$] != 23) begin errors++; $display("[TB] FAIL full.last_pos: got r%0d c%0d want r23 c23", obsRow.size() ? obsRow[$] : -1, obsCol.size() ? obsCol[$] : -1); end
    checks++; if (latency != 2) begin errors++; $display("[TB] FAIL full.latency: got %0d want 2", latency); end
    checks++; if (busyAfterFirst != 1) begin errors++; $display("[TB] FAIL full.busy_rise: got %0d want 1", busyAfterFirst); end
    checks++; if ({err_short, err_overflow} !== {expShort, expOvf}) begin errors++; $display("[TB] FAIL full.errs: got %0b%0b want %0b%0b", err_short, err_overflow, expShort, expOvf); end
  endtask

  task automatic test_random_mode1;
    stim.delete();
    for (int i = 0; i < 64; i++) stim.push_back($urandom);
    runFrame(1, 1'b1, 30, 40, 1'b1);
    buildExpected(1);
    checks++; if (obsData.size() != expData.size()) begin errors++; $display("[TB] FAIL m1.count: got %0d want %0d", obsData.size(), expData.size()); end
    for (int i = 0; i < expData.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin errors++; $display("[TB] FAIL m1.sample[%0d]: got nothing want %h", i, expData[i]); end
      else if ({obsData[i], obsRow[i], obsCol[i], obsLast[i]} !== {expData[i], expRow[i], expCol[i], expLast[i]}) begin
        errors++;
        $display("[TB] FAIL m1.sample[%0d]: got %h r%0d c%0d l%0b want %h r%0d c%0d l%0b", i,
                 obsData[i], obsRow[i], obsCol[i], obsLast[i], expData[i], expRow[i], expCol[i], expLast[i]);
      end
    end
    checks++; if (stallErrs != 0) begin errors++; $display("[TB] FAIL m1.stall_stable: got %0d breaks want 0", stallErrs); end
    checks++; if ({err_short, err_overflow} !== {expShort, expOvf}) begin errors++; $display("[TB] FAIL m1.errs: got %0b%0b want %0b%0b", err_short, err_overflow, expShort, expOvf); end
  endtask

  task automatic test_short_frame;
    stim.delete();
    for (int i = 0; i < 500; i++) stim.push_back($urandom);
    runFrame(0, 1'b1, 0, 20, 1'b0);
    buildExpected(0);
    checks++; if (obsData.size() != 500) begin errors++; $display("[TB] FAIL short.count: got %0d want 500", obsData.size()); end
    for (int i = 0; i < expData.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin errors++; $display("[TB] FAIL short.sample[%0d]: got nothing want %h", i, expData[i]); end
      else if ({obsData[i], obsRow[i], obsCol[i], obsLast[i]} !== {expData[i], expRow[i], expCol[i], expLast[i]}) begin
        errors++;
        $display("[TB] FAIL short.sample[%0d]: got %h r%0d c%0d l%0b want %h r%0d c%0d l%0b", i,
                 obsData[i], obsRow[i], obsCol[i], obsLast[i], expData[i], expRow[i], expCol[i], expLast[i]);
      end
    end
    checks++; if (obsRow.size() == 0 || obsRow[$] != 20 || obsCol[$] != 19 || !obsLast[$]) begin errors++; $display("[TB] FAIL short.last_pos: got r%0d c%0d want r20 c19 last", obsRow.size() ? obsRow[$] : -1, obsCol.size() ? obsCol[$] : -1); end
    checks++; if ({err_short, err_overflow} !== {expShort, expOvf}) begin errors++; $display("[TB] FAIL short.errs: got %0b%0b want %0b%0b", err_short, err_overflow, expShort, expOvf); end
  endtask

  task automatic test_overflow;
    stim.delete();
    for (int i = 0; i < 65; i++) stim.push_back($urandom);
    runFrame(1, 1'b0, 10, 10, 1'b0);
    buildExpected(1);
    checks++; if (obsData.size() != 64) begin errors++; $display("[TB] FAIL ovf.count: got %0d want 64", obsData.size()); end
    for (int i = 0; i < expData.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin errors++; $display("[TB] FAIL ovf.sample[%0d]: got nothing want %h", i, expData[i]); end
      else if ({obsData[i], obsRow[i], obsCol[i], obsLast[i]} !== {expData[i], expRow[i], expCol[i], expLast[i]}) begin
        errors++;
        $display("[TB] FAIL ovf.sample[%0d]: got %h r%0d c%0d l%0b want %h r%0d c%0d l%0b", i,
                 obsData[i], obsRow[i], obsCol[i], obsLast[i], expData[i], expRow[i], expCol[i], expLast[i]);
      end
    end
    checks++; if ({err_short, err_overflow} !== {expShort, expOvf}) begin errors++; $display("[TB] FAIL ovf.errs: got %0b%0b want %0b%0b", err_short, err_overflow, expShort, expOvf); end
  endtask

  task automatic test_reset_midframe;
    state = 1'b1; in_valid = 1'b1; in_data = 32'h1234_5678; in_done = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({out_valid, out_last, err_short, busy} !== 4'b1111) begin errors++; $display("[TB] FAIL rstmid.pre: got v%0b l%0b s%0b b%0b want all 1", out_valid, out_last, err_short, busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, out_valid, out_last} !== 3'b000) begin errors++; $display("[TB] FAIL rstmid.drain_ctrl: got b%0b v%0b l%0b want 000", busy, out_valid, out_last); end
    checks++; if ({err_short, err_overflow} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid.flags: got %0b%0b want 00", err_short, err_overflow); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("[TB] FAIL rstmid.out_data: got %h want 0", out_data); end
    rst = 1'b0;
    state = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rstfill.ctrl: got b%0b v%0b want 00", busy, out_valid); end
    rst = 1'b0;
    stim.delete();
    for (int i = 0; i < 64; i++) stim.push_back($urandom);
    runFrame(1, 1'b1, 0, 25, 1'b0);
    buildExpected(1);
    checks++; if (obsData.size() != expData.size()) begin errors++; $display("[TB] FAIL rstnew.count: got %0d want %0d", obsData.size(), expData.size()); end
    for (int i = 0; i < expData.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin errors++; $display("[TB] FAIL rstnew.sample[%0d]: got nothing want %h", i, expData[i]); end
      else if ({obsData[i], obsRow[i], obsCol[i], obsLast[i]} !== {expData[i], expRow[i], expCol[i], expLast[i]}) begin
        errors++;
        $display("[TB] FAIL rstnew.sample[%0d]: got %h r%0d c%0d l%0b want %h r%0d c%0d l%0b", i,
                 obsData[i], obsRow[i], obsCol[i], obsLast[i], expData[i], expRow[i], expCol[i], expLast[i]);
      end
    end
    checks++; if ({err_short, err_overflow} !== {expShort, expOvf}) begin errors++; $display("[TB] FAIL rstnew.errs: got %0b%0b want %0b%0b", err_short, err_overflow, expShort, expOvf); end
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 2; f++) begin
      stim.delete();
      for (int i = 0; i < ((f == 0) ? 64 : 30); i++) stim.push_back($urandom);
      runFrame(f == 0 ? 1 : 0, 1'b1, 0, 0, 1'b0);
      buildExpected(f == 0 ? 1 : 0);
      checks++; if (obsData.size() != expData.size()) begin errors++; $display("[TB] FAIL b2b%0d.count: got %0d want %0d", f, obsData.size(), expData.size()); end
      for (int i = 0; i < expData.size(); i++) begin
        checks++;
        if (i >= obsData.size()) begin errors++; $display("[TB] FAIL b2b%0d.sample[%0d]: got nothing want %h", f, i, expData[i]); end
        else if ({obsData[i], obsRow[i], obsCol[i], obsLast[i]} !== {expData[i], expRow[i], expCol[i], expLast[i]}) begin
          errors++;
          $display("[TB] FAIL b2b%0d.sample[%0d]: got %h r%0d c%0d l%0b want %h r%0d c%0d l%0b", f, i,
                   obsData[i], obsRow[i], obsCol[i], obsLast[i], expData[i], expRow[i], expCol[i], expLast[i]);
        end
      end
      checks++; if ({err_short, err_overflow} !== {expShort, expOvf}) begin errors++; $display("[TB] FAIL b2b%0d.errs: got %0b%0b want %0b%0b", f, err_short, err_overflow, expShort, expOvf); end
    end
  endtask

`ifdef CONV_COLLECT_BINARIZE_EN
  task automatic test_binarize;
    stim.delete();
    stim.push_back(32'hFFFF_FFFF);
    stim.push_back(32'h0000_0000);
    stim.push_back(32'h0000_0005);
    stim.push_back(32'h8000_0000);
    runFrame(0, 1'b1, 0, 0, 1'b0);
    buildExpected(0);
    checks++; if (obsData.size() != 4) begin errors++; $display("[TB] FAIL bin.count: got %0d want 4", obsData.size()); end
    for (int i = 0; i < expData.size(); i++) begin
      checks++;
      if (i >= obsData.size()) begin errors++; $display("[TB] FAIL bin.sample[%0d]: got nothing want %h", i, expData[i]); end
      else if (obsData[i] !== expData[i]) begin errors++; $display("[TB] FAIL bin.sample[%0d]: got %h want %h", i, obsData[i], expData[i]); end
    end
  endtask
`endif

  initial begin
    $display("[TB] conv_collect bench start");
    test_reset();
    test_full_frame();
    test_random_mode1();
    test_short_frame();
    test_overflow();
    test_reset_midframe();
    test_back_to_back();
`ifdef CONV_COLLECT_BINARIZE_EN
    test_binarize();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
